// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg : shared encodings for the fetch controller.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int          c_stall_cnt_w   = 3;

  localparam logic [1:0]  c_status_normal = 2'b00;
  localparam logic [1:0]  c_status_exc    = 2'b01;
  localparam logic [1:0]  c_status_irq    = 2'b10;

  localparam logic [2:0]  c_sel_seq       = 3'b000;
  localparam logic [2:0]  c_sel_br        = 3'b100;
  localparam logic [2:0]  c_sel_j         = 3'b010;
  localparam logic [2:0]  c_sel_jr        = 3'b001;

endpackage

`default_nettype wire

// File: rtl/irq_edge_latch.sv
// ---------------------------------------------------------------------------
// irq_edge_latch : rising-edge detect on irq, pending flag until taken. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
  input  logic i_take,
  output logic o_irq_pending
);

  logic r_irq_d;
  logic r_irq_pending;
  logic w_irq_rise;

  assign w_irq_rise = i_irq & ~r_irq_d;

  // A new edge arriving in the same cycle the interrupt is taken re-arms it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_d       <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_irq_d <= i_irq;
      if (w_irq_rise) begin
        r_irq_pending <= 1'b1;
      end else if (i_take) begin
        r_irq_pending <= 1'b0;
      end
    end
  end

  assign o_irq_pending = r_irq_pending;

endmodule

`default_nettype wire

// File: rtl/fetch_control.sv
// ---------------------------------------------------------------------------
// fetch_control : PC/IF_ID write, next-PC select, flush and trap control. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_control
  import fetch_ctrl_pkg::*;
#(
  parameter int JR_STALL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       branch_taken,
  input  logic       jump_id,
  input  logic       jr_id,
  input  logic       jr_hazard,
  input  logic       load_use_hazard,
  input  logic       exception,
  input  logic       irq,
  input  logic       kernel_mode,
  output logic       PC_IF_ID_Write,
  output logic [2:0] select_PC_next,
  output logic [1:0] status,
  output logic       ID_EX_flush,
  output logic       irq_ack
);

  localparam logic [c_stall_cnt_w-1:0] c_stall_load =
    c_stall_cnt_w'((JR_STALL_CYCLES > 1) ? (JR_STALL_CYCLES - 2) : 0);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_stall_cnt_w-1:0] r_stall_cnt;
  logic [c_stall_cnt_w-1:0] w_stall_cnt_nxt;
  logic                     w_irq_pending;
  logic                     w_irq_take;
  logic                     w_write;
  logic [2:0]               w_sel;
  logic [1:0]               w_status;
  logic                     w_flush;

  irq_edge_latch u_irq_edge_latch (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_irq         (irq),
    .i_take        (w_irq_take),
    .o_irq_pending (w_irq_pending)
  );

  // Interrupts are only taken on a clean RUN cycle with no redirect or hazard.
  assign w_irq_take = rst_n & w_irq_pending & ~kernel_mode & ~exception &
                      ~branch_taken & ~jump_id & ~jr_id & (r_state == RUN) &
                      ~jr_hazard & ~load_use_hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_write         = 1'b1;
    w_sel           = c_sel_seq;
    w_status        = c_status_normal;
    w_flush         = 1'b0;
    if (!rst_n) begin
      w_state_nxt     = RUN;
      w_stall_cnt_nxt = '0;
    end else if (exception) begin
      w_status        = c_status_exc;
      w_flush         = 1'b1;
      w_state_nxt     = RUN;
      w_stall_cnt_nxt = '0;
    end else if (w_irq_take) begin
      w_status = c_status_irq;
      w_flush  = 1'b1;
    end else if (branch_taken) begin
      w_sel           = c_sel_br;
      w_flush         = 1'b1;
      w_state_nxt     = RUN;
      w_stall_cnt_nxt = '0;
    end else if (r_state == STALL) begin
      w_write = 1'b0;
      w_flush = 1'b1;
      if (r_stall_cnt == '0) begin
        w_state_nxt = RUN;
      end else begin
        w_stall_cnt_nxt = r_stall_cnt - 1'b1;
      end
    end else if (jr_hazard) begin
      // The hazard cycle itself counts as the first stall cycle.
      w_write = 1'b0;
      w_flush = 1'b1;
      if (JR_STALL_CYCLES > 1) begin
        w_state_nxt     = STALL;
        w_stall_cnt_nxt = c_stall_load;
      end
    end else if (load_use_hazard) begin
      w_write = 1'b0;
      w_flush = 1'b1;
    end else if (jump_id && jr_id) begin
      w_status = c_status_exc;
      w_flush  = 1'b1;
    end else if (jump_id) begin
      w_sel = c_sel_j;
    end else if (jr_id) begin
      w_sel = c_sel_jr;
    end
  end

  assign PC_IF_ID_Write = w_write;
  assign select_PC_next = w_sel;
  assign status         = w_status;
  assign ID_EX_flush    = w_flush;
  assign irq_ack        = w_irq_take;

endmodule

`default_nettype wire
